// File: rtl/vdp_pkg.sv
// Shared definitions for the VDP VRAM arbiter.
// Holds the arbiter state encoding, the VRAM address width and the
// default guard-window length.
package vdp_pkg;

    localparam int VDP_VRAM_ADDR_W = 14;
    localparam int VDP_GUARD_DEF   = 2;
    localparam int VDP_WAIT_W_DEF  = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_RCAP = 2'd2;

endpackage

// File: rtl/vdp_sat_ctr.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_ni - synchronous active-low reset
//   clr_i  - zero the count; wins over inc_i
//   inc_i  - add one, holding at all-ones
//   cnt_o  - current count
module vdp_sat_ctr #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/vdp_vram_arb.sv
// VRAM arbiter between the display fetch engine and the CPU data port.
// Display reads always win and are never delayed; a guard window after
// each display read keeps the CPU off the RAM until the display has
// sampled its data. One CPU access is held at a time and completion is
// signalled with a one-cycle cpu_done pulse.
//
// Ports:
//   pxclk, reset            - pixel clock, synchronous active-low reset
//   vdp_dma_addr/rd_tick    - display read address and strobe
//   cpu_req/we/addr/wdata   - CPU access request
//   cpu_busy/done/rdata     - CPU status and read data
//   vram_addr/we/din/dout   - VRAM macro port (dout has 1-cycle latency)
//   stat_wait_max, stat_collisions, stat_clr
//                           - statistics, only with VDP_ARB_STATS_EN
//
// State | meaning
// IDLE  | no CPU access held; accept cpu_req
// PEND  | access held, waiting for a cycle free of ticks and guard
// RCAP  | read issued last cycle; capture vram_dout
module vdp_vram_arb
    import vdp_pkg::*;
#(
    parameter int ADDR_W = VDP_VRAM_ADDR_W,
    parameter int GUARD  = VDP_GUARD_DEF,
    parameter int WAIT_W = VDP_WAIT_W_DEF
) (
    input  logic              pxclk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] vdp_dma_addr,
    input  logic              vdp_dma_rd_tick,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_busy,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_din,
`ifdef VDP_ARB_STATS_EN
    output logic [WAIT_W-1:0] stat_wait_max,
    output logic [WAIT_W-1:0] stat_collisions,
    input  logic              stat_clr,
`endif
    input  logic [7:0]        vram_dout
);

    localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    logic [1:0]        state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [7:0]        rdata_q, rdata_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [GW-1:0]     guard_q, guard_d;
    logic [ADDR_W-1:0] vaddr_q;
    logic              issue;

    // Outputs are forced idle while reset is held so nothing reaches the RAM.
    always_comb begin
        issue     = reset && (state_q == ST_PEND) && !vdp_dma_rd_tick && (guard_q == '0);
        vram_addr = vaddr_q;
        vram_we   = 1'b0;
        vram_din  = wdata_q;
        if (!reset) begin
            vram_addr = '0;
            vram_din  = '0;
        end else if (vdp_dma_rd_tick) begin
            vram_addr = vdp_dma_addr;
        end else if (issue) begin
            vram_addr = addr_q;
            vram_we   = we_q;
        end
    end

    always_comb begin
        if (vdp_dma_rd_tick) begin
            guard_d = GW'(GUARD);
        end else if (guard_q != '0) begin
            guard_d = guard_q - GW'(1);
        end else begin
            guard_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                // done_q still high means busy was high a cycle ago: ignore.
                if (cpu_req && !busy_q && !done_q) begin
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                    busy_d  = 1'b1;
                    state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                if (issue) begin
                    if (we_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RCAP;
                    end
                end
            end
            ST_RCAP: begin
                rdata_d = vram_dout;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            guard_q <= '0;
            vaddr_q <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            guard_q <= guard_d;
            vaddr_q <= vram_addr;
        end
    end

    assign cpu_busy  = busy_q;
    assign cpu_done  = done_q;
    assign cpu_rdata = rdata_q;

`ifdef VDP_ARB_STATS_EN
    logic              blocked;
    logic [WAIT_W-1:0] dwell;
    logic [WAIT_W-1:0] wait_max_q, wait_max_d;

    assign blocked = reset && (state_q == ST_PEND) && !issue;

    // Dwell restarts every time a new access enters PEND.
    vdp_sat_ctr #(.W(WAIT_W)) u_dwell (
        .clk_i  (pxclk),
        .rst_ni (reset),
        .clr_i  (state_q != ST_PEND),
        .inc_i  (blocked),
        .cnt_o  (dwell)
    );

    vdp_sat_ctr #(.W(WAIT_W)) u_coll (
        .clk_i  (pxclk),
        .rst_ni (reset),
        .clr_i  (stat_clr),
        .inc_i  (blocked),
        .cnt_o  (stat_collisions)
    );

    always_comb begin
        wait_max_d = wait_max_q;
        if (stat_clr) begin
            wait_max_d = '0;
        end else if (issue && (dwell > wait_max_q)) begin
            wait_max_d = dwell;
        end
    end

    always_ff @(posedge pxclk) begin
        if (!reset) begin
            wait_max_q <= '0;
        end else begin
            wait_max_q <= wait_max_d;
        end
    end

    assign stat_wait_max = wait_max_q;
`endif

endmodule
